// File: rtl/stack_ctrl_if.sv
// Command, memory-bus and result signals of the stack access engine.
// The controller uses the master modport; the register file / memory side uses slave.
interface stack_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] push_data;
  logic [7:0]  sp_in;

  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  logic        done;
  logic        sp_write;
  logic [7:0]  sp_new;
  logic [15:0] pull_data;
  logic        overflow;
  logic        underflow;

  modport master (
    input  cmd_valid, cmd_op, push_data, sp_in, mem_ack, mem_rdata,
    output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output done, sp_write, sp_new, pull_data, overflow, underflow
  );

  modport slave (
    output cmd_valid, cmd_op, push_data, sp_in, mem_ack, mem_rdata,
    input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  done, sp_write, sp_new, pull_data, overflow, underflow
  );
endinterface

// File: rtl/stack_ctrl.sv
// Stack access engine: runs 8/16-bit push/pull commands against a downward-growing
// page-resident stack with one req/ack memory handshake per byte.
module stack_ctrl #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input logic          clk,
  input logic          reset,
  stack_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StFin} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  sp_q, sp_d;
  logic [7:0]  push_lo_q, push_lo_d;
  logic [7:0]  pull_lo_q, pull_lo_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic        sp_write_q, sp_write_d;
  logic [7:0]  sp_new_q, sp_new_d;
  logic [15:0] pull_data_q, pull_data_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  // op bit 0 selects pull, bit 1 selects the 16-bit form
  logic in_push, in_wide, in_ovf, in_unf;
  logic op_push, op_wide;
  logic [7:0] sp_in_inc1, sp_dec1, sp_dec2, sp_inc1, sp_inc2;

  assign in_push = ~bus.cmd_op[0];
  assign in_wide = bus.cmd_op[1];
  assign in_ovf  = in_push & (in_wide ? (bus.sp_in <= 8'h01) : (bus.sp_in == 8'h00));
  assign in_unf  = ~in_push & (in_wide ? (bus.sp_in >= 8'hFE) : (bus.sp_in == 8'hFF));

  assign op_push = ~op_q[0];
  assign op_wide = op_q[1];

  assign sp_in_inc1 = bus.sp_in + 8'd1;
  assign sp_dec1    = sp_q - 8'd1;
  assign sp_dec2    = sp_q - 8'd2;
  assign sp_inc1    = sp_q + 8'd1;
  assign sp_inc2    = sp_q + 8'd2;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sp_d        = sp_q;
    push_lo_d   = push_lo_q;
    pull_lo_d   = pull_lo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    sp_new_d    = sp_new_q;
    pull_data_d = pull_data_q;
    done_d      = 1'b0;
    sp_write_d  = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          op_d      = bus.cmd_op;
          sp_d      = bus.sp_in;
          push_lo_d = bus.push_data[7:0];
          if (in_ovf || in_unf) begin
            // Rejected commands skip the bus entirely and report in FIN.
            state_d     = StFin;
            done_d      = 1'b1;
            overflow_d  = in_ovf;
            underflow_d = in_unf;
            sp_new_d    = bus.sp_in;
          end else begin
            state_d    = StAcc0;
            mem_req_d  = 1'b1;
            mem_we_d   = in_push;
            mem_addr_d = {STACK_PAGE, (in_push ? bus.sp_in : sp_in_inc1)};
            if (in_push) begin
              mem_wdata_d = in_wide ? bus.push_data[15:8] : bus.push_data[7:0];
            end else begin
              mem_wdata_d = 8'h00;
            end
          end
        end
      end

      StAcc0: begin
        if (bus.mem_ack) begin
          if (op_wide) begin
            // Second byte is requested on the ack edge with no idle gap.
            state_d     = StAcc1;
            pull_lo_d   = bus.mem_rdata;
            mem_addr_d  = {STACK_PAGE, (op_push ? sp_dec1 : sp_inc2)};
            mem_wdata_d = op_push ? push_lo_q : 8'h00;
          end else begin
            state_d    = StFin;
            mem_req_d  = 1'b0;
            done_d     = 1'b1;
            sp_write_d = 1'b1;
            sp_new_d   = op_push ? sp_dec1 : sp_inc1;
            if (!op_push) begin
              pull_data_d = {8'h00, bus.mem_rdata};
            end
          end
        end
      end

      StAcc1: begin
        if (bus.mem_ack) begin
          state_d    = StFin;
          mem_req_d  = 1'b0;
          done_d     = 1'b1;
          sp_write_d = 1'b1;
          sp_new_d   = op_push ? sp_dec2 : sp_inc2;
          if (!op_push) begin
            pull_data_d = {bus.mem_rdata, pull_lo_q};
          end
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= 2'b00;
      sp_q        <= 8'h00;
      push_lo_q   <= 8'h00;
      pull_lo_q   <= 8'h00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      done_q      <= 1'b0;
      sp_write_q  <= 1'b0;
      sp_new_q    <= 8'hFF;
      pull_data_q <= 16'h0000;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sp_q        <= sp_d;
      push_lo_q   <= push_lo_d;
      pull_lo_q   <= pull_lo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      sp_write_q  <= sp_write_d;
      sp_new_q    <= sp_new_d;
      pull_data_q <= pull_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.done      = done_q;
  assign bus.sp_write  = sp_write_q;
  assign bus.sp_new    = sp_new_q;
  assign bus.pull_data = pull_data_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: queue-based transaction model checked every cycle, directed
// scenarios with literal expectations, then randomized commands, waits and resets.
module tb_stack_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_ctrl_if bus ();

  stack_ctrl #(.STACK_PAGE(8'h01)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- memory responder ----------------
  logic [7:0]  resp_mem [256];
  logic [23:0] wlog[$];
  int ack_mode = 0;  // 0 tied high, 1 fixed wait, 2 random
  int ack_wait = 0;
  int wcnt = 0;

  assign bus.mem_rdata = resp_mem[bus.mem_addr[7:0]];

  always @(negedge clk) begin
    #2;
    if (reset) begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
    end else begin
      case (ack_mode)
        0: bus.mem_ack = 1'b1;
        1: begin
          if (bus.mem_ack === 1'b1) wcnt = 0;
          if (bus.mem_req) begin
            bus.mem_ack = (wcnt >= ack_wait);
            if (!bus.mem_ack) wcnt++;
          end else begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
          end
        end
        default: bus.mem_ack = ($urandom_range(0, 2) != 0);
      endcase
      if (bus.mem_ack && bus.mem_req && bus.mem_we) begin
        resp_mem[bus.mem_addr[7:0]] = bus.mem_wdata;
        wlog.push_back({bus.mem_addr, bus.mem_wdata});
      end
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } acc_t;

  function automatic acc_t mk(input logic we, input logic [7:0] off, input logic [7:0] wd);
    acc_t a;
    a.we    = we;
    a.addr  = {8'h01, off};
    a.wdata = wd;
    return a;
  endfunction

  logic [7:0]  mmem [256];
  acc_t        mq[$];
  logic [7:0]  m_rd[$];
  bit          m_busy = 1'b0, m_fin = 1'b0, m_ov = 1'b0, m_un = 1'b0;
  logic [7:0]  m_spn = 8'hFF;
  logic [1:0]  m_op = 2'b00;
  logic [15:0] m_pull = 16'h0000;

  always @(posedge clk) begin : model
    acc_t a;
    logic [7:0] s;
    logic [15:0] d;
    if (reset) begin
      mq.delete();
      m_rd.delete();
      m_busy = 0; m_fin = 0; m_ov = 0; m_un = 0;
      m_pull = 16'h0000;
    end else if (m_fin) begin
      m_fin = 0; m_busy = 0; m_ov = 0; m_un = 0;
    end else if (m_busy) begin
      if (bus.mem_ack && mq.size() > 0) begin
        a = mq.pop_front();
        if (a.we) mmem[a.addr[7:0]] = a.wdata;
        else m_rd.push_back(mmem[a.addr[7:0]]);
        if (mq.size() == 0) begin
          m_fin = 1;
          if (m_op == 2'd1) m_pull = {8'h00, m_rd[0]};
          else if (m_op == 2'd3) m_pull = {m_rd[1], m_rd[0]};
          m_rd.delete();
        end
      end
    end else if (bus.cmd_valid) begin
      s = bus.sp_in;
      d = bus.push_data;
      m_op = bus.cmd_op;
      m_busy = 1;
      m_ov = 0;
      m_un = 0;
      case (m_op)
        2'd0: begin
          m_ov = (s == 8'h00);
          m_spn = s - 8'd1;
          if (!m_ov) mq.push_back(mk(1'b1, s, d[7:0]));
        end
        2'd1: begin
          m_un = (s == 8'hFF);
          m_spn = s + 8'd1;
          if (!m_un) mq.push_back(mk(1'b0, s + 8'd1, 8'h00));
        end
        2'd2: begin
          m_ov = (s <= 8'h01);
          m_spn = s - 8'd2;
          if (!m_ov) begin
            mq.push_back(mk(1'b1, s, d[15:8]));
            mq.push_back(mk(1'b1, s - 8'd1, d[7:0]));
          end
        end
        default: begin
          m_un = (s >= 8'hFE);
          m_spn = s + 8'd2;
          if (!m_un) begin
            mq.push_back(mk(1'b0, s + 8'd1, 8'h00));
            mq.push_back(mk(1'b0, s + 8'd2, 8'h00));
          end
        end
      endcase
      if (m_ov || m_un) begin
        m_fin = 1;
        m_spn = s;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", bus.cmd_ready, !m_busy);
      chk("mem_req", bus.mem_req, mq.size() > 0);
      if (mq.size() > 0 && bus.mem_req) begin
        chk("mem_we", bus.mem_we, mq[0].we);
        chk("mem_addr", bus.mem_addr, mq[0].addr);
        if (mq[0].we) chk("mem_wdata", bus.mem_wdata, mq[0].wdata);
      end
      chk("done", bus.done, m_fin);
      chk("sp_write", bus.sp_write, m_fin && !m_ov && !m_un);
      chk("overflow", bus.overflow, m_fin && m_ov);
      chk("underflow", bus.underflow, m_fin && m_un);
      if (m_fin) chk("sp_new", bus.sp_new, m_spn);
      chk("pull_data", bus.pull_data, m_pull);
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] r_pull;
  logic [7:0]  r_spn;
  logic        r_ov, r_un, r_sw;

  // Called at a negedge; returns at the negedge where done is seen (or after an abort).
  task automatic issue(input logic [1:0] op, input logic [15:0] d, input logic [7:0] sp,
                       input int abort_at, input bit junk, output int lat);
    int n;
    bit got;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.push_data = d;
    bus.sp_in     = sp;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    lat = 0;
    if (!bus.cmd_ready) begin
      bus.cmd_valid = 1'b0;
      timeout_fail("cmd_ready_wait");
      return;
    end
    got = 1'b0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (bus.done) begin
        got    = 1'b1;
        r_pull = bus.pull_data;
        r_spn  = bus.sp_new;
        r_ov   = bus.overflow;
        r_un   = bus.underflow;
        r_sw   = bus.sp_write;
        bus.cmd_valid = 1'b0;
        break;
      end
      if (abort_at != 0 && lat == abort_at) begin
        bus.cmd_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (junk) begin
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op    = 2'($urandom_range(0, 3));
        bus.sp_in     = 8'($urandom_range(0, 255));
        bus.push_data = 16'($urandom_range(0, 65535));
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end
    if (!got) timeout_fail("done_wait");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n0, n;
    logic [7:0] edges [6];
    edges = '{8'h00, 8'h01, 8'h02, 8'hFD, 8'hFE, 8'hFF};
    for (int i = 0; i < 256; i++) begin
      resp_mem[i] = 8'($urandom_range(0, 255));
      mmem[i]     = resp_mem[i];
    end
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.push_data = 16'h0000;
    bus.sp_in     = 8'h00;
    ack_mode = 0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_sp_new", bus.sp_new, 8'hFF);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_mem_wdata", bus.mem_wdata, 8'h00);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_pull_data", bus.pull_data, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", bus.cmd_ready, 1'b1);

    // PUSH8 zero-wait
    n0 = wlog.size();
    issue(2'd0, 16'h00A5, 8'hFF, 0, 1'b0, lat);
    chk("push8_lat", lat, 2);
    chk("push8_spn", r_spn, 8'hFE);
    chk("push8_sw", r_sw, 1'b1);
    chk("push8_nwrites", wlog.size() - n0, 1);
    chk("push8_write", wlog[wlog.size() - 1], 24'h01FFA5);

    // PUSH16 with two wait cycles per byte
    ack_mode = 1;
    ack_wait = 2;
    n0 = wlog.size();
    issue(2'd2, 16'h1234, 8'hFE, 0, 1'b0, lat);
    chk("push16_lat", lat, 7);
    chk("push16_spn", r_spn, 8'hFC);
    chk("push16_nwrites", wlog.size() - n0, 2);
    chk("push16_write_hi", wlog[n0], 24'h01FE12);
    chk("push16_write_lo", wlog[n0 + 1], 24'h01FD34);

    // PULL16 zero-wait reads back what was pushed
    ack_mode = 0;
    issue(2'd3, 16'h0000, 8'hFC, 0, 1'b0, lat);
    chk("pull16_lat", lat, 3);
    chk("pull16_data", r_pull, 16'h1234);
    chk("pull16_spn", r_spn, 8'hFE);

    // Rejected commands
    n0 = wlog.size();
    issue(2'd1, 16'h0000, 8'hFF, 0, 1'b0, lat);
    chk("pull8_unf_lat", lat, 1);
    chk("pull8_unf_flag", r_un, 1'b1);
    chk("pull8_unf_sw", r_sw, 1'b0);
    chk("pull8_unf_spn", r_spn, 8'hFF);
    issue(2'd2, 16'hBEEF, 8'h01, 0, 1'b0, lat);
    chk("push16_ovf_lat", lat, 1);
    chk("push16_ovf_flag", r_ov, 1'b1);
    chk("push16_ovf_sw", r_sw, 1'b0);
    chk("ovf_nwrites", wlog.size() - n0, 0);

    // Reset in the first ACC1 cycle of a PUSH16
    issue(2'd2, 16'hBEEF, 8'h80, 2, 1'b0, lat);
    chk("abort_mem_req", bus.mem_req, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_sp_write", bus.sp_write, 1'b0);
    chk("abort_ready", bus.cmd_ready, 1'b1);
    chk("abort_partial_write", wlog[wlog.size() - 1], 24'h0180BE);
    issue(2'd0, 16'h0042, 8'h80, 0, 1'b0, lat);
    chk("after_abort_lat", lat, 2);
    chk("after_abort_write", wlog[wlog.size() - 1], 24'h018042);
    chk("after_abort_spn", r_spn, 8'h7F);

    // Back-to-back PULL8 with cmd_valid held high
    resp_mem[8'hF1] = 8'h77; mmem[8'hF1] = 8'h77;
    resp_mem[8'hF2] = 8'h88; mmem[8'hF2] = 8'h88;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd1;
    bus.sp_in     = 8'hF0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_first_lat", lat, 2);
    chk("b2b_first_data", bus.pull_data, 16'h0077);
    bus.sp_in = 8'hF1;
    @(negedge clk);
    chk("b2b_ready_after_fin", bus.cmd_ready, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 20);
    bus.cmd_valid = 1'b0;
    chk("b2b_second_lat", n, 2);
    chk("b2b_second_data", bus.pull_data, 16'h0088);
    chk("b2b_second_spn", bus.sp_new, 8'hF2);

    // Randomized commands, wait patterns, ignored requests and mid-op resets
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  op;
      logic [7:0]  sp;
      logic [15:0] d;
      int ab;
      op = 2'($urandom_range(0, 3));
      sp = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)]
                                       : 8'($urandom_range(0, 255));
      d  = 16'($urandom_range(0, 65535));
      ack_mode = $urandom_range(0, 2);
      ack_wait = $urandom_range(0, 3);
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 4) : 0;
      issue(op, d, sp, ab, 1'($urandom_range(0, 1)), lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Stack access engine between the register file's SP and the memory bus.
- Executes 8-bit and 16-bit push/pull commands: forms page-1 stack addresses, runs a req/ack memory handshake per byte, and returns the updated SP plus the pulled data.
- The controller drives `sp_write`/`sp_new` into the register file's `sp_write`/`data_in` path.
- Stack grows downward; SP points at the next free location.

Parameters:
- STACK_PAGE, 8'h01, high address byte of every stack access.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high when in IDLE; a command is accepted when cmd_valid && cmd_ready
- cmd_op  input  2  00 PUSH8, 01 PULL8, 10 PUSH16, 11 PULL16
- push_data  input  16  push payload; PUSH8 uses [7:0]
- sp_in  input  8  current SP, sampled on accept
- mem_req  output  1  memory access request
- mem_we  output  1  1 = write, 0 = read; valid while mem_req
- mem_addr  output  16  {STACK_PAGE, byte offset}
- mem_wdata  output  8  write data
- mem_ack  input  1  access complete; read data valid in the same cycle
- mem_rdata  input  8  read data
- done  output  1  one-cycle completion pulse
- sp_write  output  1  one-cycle SP update strobe, coincident with done
- sp_new  output  8  updated SP, valid with done
- pull_data  output  16  pulled value; PULL8 zero-extends to {8'h00, byte}; holds until the next pull completes
- overflow  output  1  valid with done: push rejected
- underflow  output  1  valid with done: pull rejected

Behaviour:
- Reset is synchronous and active-high.
  - On reset: state=IDLE; mem_req=0, mem_we=0, mem_addr=16'h0000, mem_wdata=0, done=0, sp_write=0, sp_new=8'hFF, pull_data=0, overflow=0, underflow=0.
  - cmd_ready is 1 on the first cycle after reset deasserts.
- All outputs are registered except cmd_ready, which equals (state==IDLE).
- States: IDLE, ACC0, ACC1, FIN.
- IDLE: on accept, latch op, sp_in, push_data.
  - Overflow if PUSH8 with sp==8'h00, or PUSH16 with sp<=8'h01.
  - Underflow if PULL8 with sp==8'hFF, or PULL16 with sp>=8'hFE.
  - On either error go to FIN with the flag set: no memory access, sp_write=0, sp_new=sp.
  - Otherwise go to ACC0 with mem_req=1.
- Byte ordering:
  - PUSH8: write push_data[7:0] @ sp; new SP = sp-1.
  - PUSH16: ACC0 writes [15:8] @ sp; ACC1 writes [7:0] @ sp-1; new SP = sp-2.
  - PULL8: read @ sp+1; new SP = sp+1.
  - PULL16: ACC0 reads low byte @ sp+1; ACC1 reads high byte @ sp+2; new SP = sp+2.
- Offset arithmetic is 8-bit modulo. Wrap cannot occur because error checks precede any access.
- ACCx handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until the cycle where mem_ack=1.
  - On ack: capture mem_rdata for pulls, then advance (ACC0→ACC1 for 16-bit ops, otherwise →FIN).
  - Between ACC0 and ACC1 there is no idle cycle: mem_req stays 1 and address/data change on the ack edge.
  - mem_ack while mem_req=0 is ignored.
- FIN (one cycle):
  - done=1; sp_write=1 if no error; sp_new, pull_data, overflow, underflow valid.
  - mem_req=0; next state IDLE.
  - done, sp_write, overflow and underflow return to 0 the following cycle.
- Latency (accept edge to done) with zero-wait memory: 8-bit = 2 cycles, 16-bit = 3 cycles, error = 1 cycle. Each wait cycle adds 1.
- Back-to-back: a new command is accepted the cycle after FIN, since cmd_ready=1 in IDLE.
- cmd_valid outside IDLE is ignored and not queued.
- Reset mid-operation: abort immediately; mem_req=0 at the next edge. No SP update and no done pulse. A partially completed PUSH16 leaves memory written but SP unchanged.

Test Plan:
- Reset, then PUSH8 push_data=16'h00A5, sp_in=8'hFF, mem_ack tied 1 → one write at 16'h01FF, data A5; done 2 cycles after accept; sp_new=8'hFE, sp_write=1.
- PUSH16 push_data=16'h1234, sp_in=8'hFE, ack delayed 2 cycles per byte → write 12 @ 01FE, then 34 @ 01FD; request fields stable during waits; done 7 cycles after accept; sp_new=8'hFC.
- PULL16 sp_in=8'hFC, memory 01FD=34, 01FE=12, zero-wait → reads 01FD then 01FE; pull_data=16'h1234; sp_new=8'hFE; done 3 cycles after accept.
- PULL8 sp_in=8'hFF → no mem_req; done 1 cycle after accept with underflow=1, sp_write=0. PUSH16 sp_in=8'h01 → overflow=1, no access.
- PUSH16 with reset asserted in the first cycle of ACC1 → mem_req=0 next cycle, no done or sp_write, cmd_ready=1 after reset. A following PUSH8 sp_in=8'h80 writes at 0180.
- Two back-to-back PULL8 with cmd_valid held high, sp_in=8'hF0 then 8'hF1, mem 01F1=77, 01F2=88 → second accept the cycle after the first done; pull_data 16'h0077 then 16'h0088.
